xif_mem_responder: RTL and testbench



---
 rtl/xif_mem_responder.sv | 214 +++++++++++++++++++++
 tb/tb_xif_mem_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xif_mem_responder.sv
// -----------------------------------------------------------------------------
// xif_mem_responder
//
// Memory-side responder for the CORE-V-XIF memory request/response and memory
// result interfaces. Requests are served from an internal word-addressed
// memory. Each request is checked for alignment, size and range. Requests
// without an exception return one in-order mem_result beat after a fixed
// LATENCY.
//
// Parameters:
//   X_ID_WIDTH  - instruction ID width
//   MEM_DEPTH   - number of 32-bit words (word index = addr[31:2])
//   LATENCY     - edges from accept to result (1..8)
//   READY_DELAY - cycles mem_valid must be held before mem_ready rises (0..7)
//
// Ports:
//   ck                 in   clock, rising edge
//   rst                in   asynchronous active-low reset
//   mem_valid          in   request valid
//   mem_ready          out  request accepted this cycle (combinational)
//   mem_req_id         in   request instruction ID
//   mem_req_addr       in   byte address
//   mem_req_mode       in   privilege mode (ignored)
//   mem_req_we         in   1 = store
//   mem_req_be         in   store byte enables
//   mem_req_size       in   0 = byte, 1 = half, 2 = word, others illegal
//   mem_req_wdata      in   store data
//   mem_req_last       in   last beat (ignored)
//   mem_req_spec       in   speculative (ignored, stores always performed)
//   mem_resp_exc       out  exception flag, valid while mem_valid is high
//   mem_resp_exccode   out  exception code, valid while mem_valid is high
//   mem_resp_dbg       out  tied 0
//   mem_result_valid   out  one-cycle result pulse (no ready on this interface)
//   mem_result_id      out  ID of the returned request
//   mem_result_rdata   out  full aligned load word, 0 for stores
//   mem_result_err     out  tied 0
//   mem_result_dbg     out  tied 0
//
// Handshake: a request transfers on a rising edge where mem_valid and
// mem_ready are both high. mem_ready never rises without mem_valid, and the
// requester holds the request fields stable until the transfer edge. The
// result interface is push-only: mem_result_valid is a single-cycle pulse
// the requester must take.
// -----------------------------------------------------------------------------
module xif_mem_responder #(
  parameter int X_ID_WIDTH  = 4,
  parameter int MEM_DEPTH   = 256,
  parameter int LATENCY     = 2,
  parameter int READY_DELAY = 0
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [X_ID_WIDTH-1:0] mem_req_id,
  input  logic [31:0]           mem_req_addr,
  input  logic [1:0]            mem_req_mode,
  input  logic                  mem_req_we,
  input  logic [3:0]            mem_req_be,
  input  logic [2:0]            mem_req_size,
  input  logic [31:0]           mem_req_wdata,
  input  logic                  mem_req_last,
  input  logic                  mem_req_spec,
  output logic                  mem_resp_exc,
  output logic [5:0]            mem_resp_exccode,
  output logic                  mem_resp_dbg,
  output logic                  mem_result_valid,
  output logic [X_ID_WIDTH-1:0] mem_result_id,
  output logic [31:0]           mem_result_rdata,
  output logic                  mem_result_err,
  output logic                  mem_result_dbg
);

  localparam int          AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(MEM_DEPTH);
  localparam logic [2:0]  RDY_W   = 3'(READY_DELAY);

  // Exception codes
  localparam logic [5:0] EXC_LD_MISALIGN = 6'd4;
  localparam logic [5:0] EXC_LD_FAULT    = 6'd5;
  localparam logic [5:0] EXC_ST_MISALIGN = 6'd6;
  localparam logic [5:0] EXC_ST_FAULT    = 6'd7;

  // ---------------------------------------------------------------------------
  // Ready generation
  // ---------------------------------------------------------------------------
  logic [2:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    mem_ready  = mem_valid && (wait_cnt_q == RDY_W);
    wait_cnt_d = wait_cnt_q;
    // The counter measures how long the current request has been waiting, so
    // it restarts both when the request goes away and when it is taken.
    if (!mem_valid || mem_ready) begin
      wait_cnt_d = 3'd0;
    end else begin
      wait_cnt_d = wait_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= 3'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Exception checks (purely a function of the current request fields)
  // ---------------------------------------------------------------------------
  logic misaligned;
  logic illegal_size;
  logic out_of_range;

  always_comb begin
    misaligned   = ((mem_req_size == 3'd1) && mem_req_addr[0]) ||
                   ((mem_req_size == 3'd2) && (mem_req_addr[1:0] != 2'b00));
    illegal_size = (mem_req_size > 3'd2);
    out_of_range = (mem_req_addr[31:2] >= DEPTH_W);

    mem_resp_exc     = 1'b0;
    mem_resp_exccode = 6'd0;
    // Alignment/size faults take priority over range faults.
    if (misaligned || illegal_size) begin
      mem_resp_exc     = 1'b1;
      mem_resp_exccode = mem_req_we ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
    end else if (out_of_range) begin
      mem_resp_exc     = 1'b1;
      mem_resp_exccode = mem_req_we ? EXC_ST_FAULT : EXC_LD_FAULT;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory
  // ---------------------------------------------------------------------------
  logic [31:0]   mem_q [MEM_DEPTH];
  logic [AW-1:0] word_idx;
  logic          accept;
  logic          store_en;

  always_comb begin
    word_idx = mem_req_addr[AW+1:2];
    // Faulting requests are acknowledged but have no side effect and no result.
    accept   = mem_valid && mem_ready && !mem_resp_exc;
    store_en = accept && mem_req_we;
  end

  // Contents are deliberately outside the reset domain so they survive reset.
  always_ff @(posedge ck) begin
    if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_req_be[b]) begin
          mem_q[word_idx][8*b +: 8] <= mem_req_wdata[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result pipeline: stage 0 is loaded on the accept edge, the last stage
  // drives the outputs. Bubbles carry zero id/rdata so the outputs read 0
  // whenever no result is being presented.
  // ---------------------------------------------------------------------------
  logic                  pipe_valid_q [LATENCY];
  logic                  pipe_valid_d [LATENCY];
  logic [X_ID_WIDTH-1:0] pipe_id_q    [LATENCY];
  logic [X_ID_WIDTH-1:0] pipe_id_d    [LATENCY];
  logic [31:0]           pipe_rdata_q [LATENCY];
  logic [31:0]           pipe_rdata_d [LATENCY];

  always_comb begin
    pipe_valid_d[0] = accept;
    pipe_id_d[0]    = accept ? mem_req_id : '0;
    // The array read sees the pre-edge contents; a store on the previous
    // edge is already visible, which gives store-then-load ordering.
    pipe_rdata_d[0] = (accept && !mem_req_we) ? mem_q[word_idx] : 32'd0;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_id_d[i]    = pipe_id_q[i-1];
      pipe_rdata_d[i] = pipe_rdata_q[i-1];
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_valid_q[i] <= 1'b0;
        pipe_id_q[i]    <= '0;
        pipe_rdata_q[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_d[i];
        pipe_id_q[i]    <= pipe_id_d[i];
        pipe_rdata_q[i] <= pipe_rdata_d[i];
      end
    end
  end

  assign mem_result_valid = pipe_valid_q[LATENCY-1];
  assign mem_result_id    = pipe_id_q[LATENCY-1];
  assign mem_result_rdata = pipe_rdata_q[LATENCY-1];

  // Tied outputs
  assign mem_resp_dbg   = 1'b0;
  assign mem_result_err = 1'b0;
  assign mem_result_dbg = 1'b0;

  // Fields carried by the protocol that this responder does not act on.
  logic unused_ok;
  assign unused_ok = ^{mem_req_mode, mem_req_last, mem_req_spec};

endmodule

// File: tb/tb_xif_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_xif_mem_responder
//
// Three responder instances share the request fields and reset; each has its
// own mem_valid:
//   dut_a : LATENCY 2, READY_DELAY 0  (main function, exceptions, streaming)
//   dut_b : LATENCY 3, READY_DELAY 0  (reset while results are in flight)
//   dut_c : LATENCY 2, READY_DELAY 3  (ready delay)
// -----------------------------------------------------------------------------
module tb_xif_mem_responder;

  localparam int LAT_A = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic ck = 1'b0;
  logic rst_n = 1'b0;
  always #5 ck = ~ck;

  int cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  // Shared request fields
  logic [3:0]  req_id    = '0;
  logic [31:0] req_addr  = '0;
  logic [1:0]  req_mode  = '0;
  logic        req_we    = 1'b0;
  logic [3:0]  req_be    = '0;
  logic [2:0]  req_size  = '0;
  logic [31:0] req_wdata = '0;
  logic        req_last  = 1'b1;
  logic        req_spec  = 1'b0;

  logic va = 1'b0, vb = 1'b0, vc = 1'b0;

  logic       ready_a, exc_a, rdbg_a, rvalid_a, rerr_a, resdbg_a;
  logic [5:0] code_a;
  logic [3:0] rid_a;
  logic [31:0] rdata_a;
  logic       ready_b, exc_b, rdbg_b, rvalid_b, rerr_b, resdbg_b;
  logic [5:0] code_b;
  logic [3:0] rid_b;
  logic [31:0] rdata_b;
  logic       ready_c, exc_c, rdbg_c, rvalid_c, rerr_c, resdbg_c;
  logic [5:0] code_c;
  logic [3:0] rid_c;
  logic [31:0] rdata_c;

  xif_mem_responder #(.X_ID_WIDTH(4), .MEM_DEPTH(256), .LATENCY(2), .READY_DELAY(0)) dut_a (
    .ck(ck), .rst(rst_n), .mem_valid(va), .mem_ready(ready_a),
    .mem_req_id(req_id), .mem_req_addr(req_addr), .mem_req_mode(req_mode),
    .mem_req_we(req_we), .mem_req_be(req_be), .mem_req_size(req_size),
    .mem_req_wdata(req_wdata), .mem_req_last(req_last), .mem_req_spec(req_spec),
    .mem_resp_exc(exc_a), .mem_resp_exccode(code_a), .mem_resp_dbg(rdbg_a),
    .mem_result_valid(rvalid_a), .mem_result_id(rid_a), .mem_result_rdata(rdata_a),
    .mem_result_err(rerr_a), .mem_result_dbg(resdbg_a)
  );

  xif_mem_responder #(.X_ID_WIDTH(4), .MEM_DEPTH(256), .LATENCY(3), .READY_DELAY(0)) dut_b (
    .ck(ck), .rst(rst_n), .mem_valid(vb), .mem_ready(ready_b),
    .mem_req_id(req_id), .mem_req_addr(req_addr), .mem_req_mode(req_mode),
    .mem_req_we(req_we), .mem_req_be(req_be), .mem_req_size(req_size),
    .mem_req_wdata(req_wdata), .mem_req_last(req_last), .mem_req_spec(req_spec),
    .mem_resp_exc(exc_b), .mem_resp_exccode(code_b), .mem_resp_dbg(rdbg_b),
    .mem_result_valid(rvalid_b), .mem_result_id(rid_b), .mem_result_rdata(rdata_b),
    .mem_result_err(rerr_b), .mem_result_dbg(resdbg_b)
  );

  xif_mem_responder #(.X_ID_WIDTH(4), .MEM_DEPTH(256), .LATENCY(2), .READY_DELAY(3)) dut_c (
    .ck(ck), .rst(rst_n), .mem_valid(vc), .mem_ready(ready_c),
    .mem_req_id(req_id), .mem_req_addr(req_addr), .mem_req_mode(req_mode),
    .mem_req_we(req_we), .mem_req_be(req_be), .mem_req_size(req_size),
    .mem_req_wdata(req_wdata), .mem_req_last(req_last), .mem_req_spec(req_spec),
    .mem_resp_exc(exc_c), .mem_resp_exccode(code_c), .mem_resp_dbg(rdbg_c),
    .mem_result_valid(rvalid_c), .mem_result_id(rid_c), .mem_result_rdata(rdata_c),
    .mem_result_err(rerr_c), .mem_result_dbg(resdbg_c)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard for dut_a: {due cycle[15:0], id[3:0], rdata[31:0]}
  logic [51:0] exp_q[$];
  logic [51:0] mon_e;

  always @(negedge ck) begin
    if (rst_n && rvalid_a) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'(rvalid_a), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_id",    64'(rid_a),     64'(mon_e[35:32]));
        check("res_rdata", 64'(rdata_a),   64'(mon_e[31:0]));
        check("res_cycle", 64'(cyc[15:0]), 64'(mon_e[51:36]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  function automatic logic sel_ready(input int sel);
    case (sel)
      0:       return ready_a;
      1:       return ready_b;
      default: return ready_c;
    endcase
  endfunction

  function automatic logic [6:0] sel_resp(input int sel);
    case (sel)
      0:       return {exc_a, code_a};
      1:       return {exc_b, code_b};
      default: return {exc_c, code_c};
    endcase
  endfunction

  // Called #1 after a rising edge; returns #1 after the handshake edge with
  // valid dropped, so back-to-back calls keep valid continuously high.
  task automatic issue(input int sel, input logic we_i, input logic [31:0] a,
                       input logic [2:0] sz, input logic [3:0] be_i,
                       input logic [31:0] wd, input logic [3:0] id,
                       input logic [31:0] exp_rd, input logic [5:0] exp_code);
    logic got;
    req_we = we_i; req_addr = a; req_size = sz; req_be = be_i;
    req_wdata = wd; req_id = id;
    va = (sel == 0); vb = (sel == 1); vc = (sel == 2);
    got = 1'b0;
    for (int k = 0; k < 16 && !got; k++) begin
      @(negedge ck);
      if (sel_ready(sel)) begin
        got = 1'b1;
        check("resp_exc",     64'(sel_resp(sel)[6]),   64'(exp_code != 6'd0));
        check("resp_exccode", 64'(sel_resp(sel)[5:0]), 64'(exp_code));
        if (sel == 0 && exp_code == 6'd0)
          exp_q.push_back({16'(cyc + LAT_A), id, exp_rd});
      end
    end
    if (!got) check("ready_timeout", 64'd0, 64'd1);
    @(posedge ck); #1;
    va = 1'b0; vb = 1'b0; vc = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int   cnt;
  logic found;

  initial begin
    // Reset values
    #3;
    check("rst_ready",   64'(ready_a),  64'd0);
    check("rst_exc",     64'(exc_a),    64'd0);
    check("rst_exccode", 64'(code_a),   64'd0);
    check("rst_rvalid",  64'(rvalid_a), 64'd0);
    check("rst_rid",     64'(rid_a),    64'd0);
    check("rst_rdata",   64'(rdata_a),  64'd0);
    check("rst_tied",    64'({rdbg_a, rerr_a, resdbg_a}), 64'd0);
    repeat (3) @(posedge ck);
    #1 rst_n = 1'b1;
    idle(1);

    // Word store then load, back to back
    issue(0, 1'b1, 32'h40, 3'd2, 4'hF, 32'hDEADBEEF, 4'd1, 32'h0,        6'd0);
    issue(0, 1'b0, 32'h40, 3'd2, 4'h0, 32'h0,        4'd2, 32'hDEADBEEF, 6'd0);

    // Partial byte-enable store
    issue(0, 1'b1, 32'h44, 3'd2, 4'hF,    32'h11223344, 4'd3, 32'h0, 6'd0);
    issue(0, 1'b1, 32'h44, 3'd2, 4'b0101, 32'hAABBCCDD, 4'd4, 32'h0, 6'd0);
    issue(0, 1'b0, 32'h44, 3'd2, 4'h0,    32'h0,        4'd5, 32'h11BB33DD, 6'd0);

    // Word 0 is the alias target of an out-of-range store at 0x400
    issue(0, 1'b1, 32'h00, 3'd2, 4'hF, 32'h0BADF00D, 4'd6, 32'h0, 6'd0);
    // be = 0 writes nothing but still returns a result
    issue(0, 1'b1, 32'h00, 3'd2, 4'h0, 32'hFFFFFFFF, 4'd7, 32'h0, 6'd0);

    // Exceptions: no result, no side effect
    issue(0, 1'b0, 32'h42,  3'd2, 4'h0, 32'h0,        4'd8, 32'h0, 6'd4);
    issue(0, 1'b1, 32'h400, 3'd2, 4'hF, 32'h12345678, 4'd9, 32'h0, 6'd7);
    issue(0, 1'b0, 32'h40,  3'd3, 4'h0, 32'h0,        4'd10, 32'h0, 6'd4);
    issue(0, 1'b1, 32'h41,  3'd1, 4'hF, 32'h12345678, 4'd11, 32'h0, 6'd6);
    issue(0, 1'b0, 32'h400, 3'd2, 4'h0, 32'h0,        4'd12, 32'h0, 6'd5);
    issue(0, 1'b0, 32'h401, 3'd2, 4'h0, 32'h0,        4'd13, 32'h0, 6'd4);

    // Memory unchanged by faulting requests; byte load returns the full word
    issue(0, 1'b0, 32'h00, 3'd2, 4'h0, 32'h0, 4'd14, 32'h0BADF00D, 6'd0);
    issue(0, 1'b0, 32'h43, 3'd0, 4'h0, 32'h0, 4'd15, 32'hDEADBEEF, 6'd0);
    issue(0, 1'b0, 32'h46, 3'd1, 4'h0, 32'h0, 4'd0,  32'h11BB33DD, 6'd0);
    idle(4);

    // Sustained in-order stream
    for (int i = 0; i < 16; i++)
      issue(0, 1'b1, 32'h80 + 32'(4*i), 3'd2, 4'hF, 32'hC0DE0000 + 32'(i), 4'(i), 32'h0, 6'd0);
    for (int i = 0; i < 16; i++)
      issue(0, 1'b0, 32'h80 + 32'(4*i), 3'd2, 4'h0, 32'h0, 4'(i), 32'hC0DE0000 + 32'(i), 6'd0);
    idle(6);
    check("a_drained", 64'(exp_q.size()), 64'd0);

    // Reset with results in flight (dut_b, LATENCY 3)
    issue(1, 1'b1, 32'h10, 3'd2, 4'hF, 32'h5A5A1234, 4'd0, 32'h0, 6'd0);
    idle(5);
    issue(1, 1'b0, 32'h10, 3'd2, 4'h0, 32'h0, 4'd1, 32'h0, 6'd0);
    issue(1, 1'b0, 32'h10, 3'd2, 4'h0, 32'h0, 4'd2, 32'h0, 6'd0);
    issue(1, 1'b0, 32'h10, 3'd2, 4'h0, 32'h0, 4'd3, 32'h0, 6'd0);
    @(posedge ck);
    #2 rst_n = 1'b0;
    #1;
    check("b_rst_rvalid", 64'(rvalid_b), 64'd0);
    check("b_rst_rid",    64'(rid_b),    64'd0);
    check("b_rst_rdata",  64'(rdata_b),  64'd0);
    check("b_rst_ready",  64'(ready_b),  64'd0);
    check("b_rst_resp",   64'({exc_b, code_b}), 64'd0);
    check("b_rst_tied",   64'({rdbg_b, rerr_b, resdbg_b}), 64'd0);
    repeat (2) @(posedge ck);
    #1 rst_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge ck);
      if (rvalid_b) cnt++;
    end
    check("b_no_result_after_rst", 64'(cnt), 64'd0);
    @(posedge ck); #1;
    issue(1, 1'b0, 32'h10, 3'd2, 4'h0, 32'h0, 4'd7, 32'h0, 6'd0);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge ck);
      if (rvalid_b) begin
        found = 1'b1;
        check("b_retained_id",    64'(rid_b),   64'd7);
        check("b_retained_rdata", 64'(rdata_b), 64'h5A5A1234);
      end
    end
    check("b_result_seen", 64'(found), 64'd1);

    // Ready delay (dut_c, READY_DELAY 3) under continuous mem_valid
    @(posedge ck); #1;
    req_we = 1'b0; req_addr = 32'h20; req_size = 3'd2; req_be = 4'h0; req_id = 4'd5;
    vc = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge ck);
      check($sformatf("c_ready_cyc%0d", i), 64'(ready_c), 64'((i == 4) || (i == 8)));
    end
    @(posedge ck); #1 vc = 1'b0;
    @(negedge ck);
    check("c_ready_idle", 64'(ready_c), 64'd0);

    idle(4);
    check("a_final_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
